// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. FWFT selects between a registered read port
// (one-cycle latency) and a first-word-fall-through head view.
module sync_fifo_ctrl #(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [DSIZE-1:0] wdata,
    input  logic             ren,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   level,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned    DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] AfLevel = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AeLevel = (ASIZE+1)'(AE_LEVEL);

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic [ASIZE:0] level_q, level_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic           afull_q, afull_d;
    logic           aempty_q, aempty_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE-1:0] raddr;

    // Accept decisions look only at the registered flags, so a same-cycle read never frees a
    // slot for a write and a same-cycle write never feeds a read.
    always_comb begin
        wr_acc = wen && !full_q;
        rd_acc = ren && !empty_q;
        waddr  = wptr_q[ASIZE-1:0];
        raddr  = rptr_q[ASIZE-1:0];
    end

    // Next-state for pointers, occupancy, status flags and sticky errors.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Wrap bit differs and addresses match: the writer is one full lap ahead.
        full_d   = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                   (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
        empty_d  = (wptr_d == rptr_d);
        afull_d  = (level_d >= AfLevel);
        aempty_d = (level_d <= AeLevel);

        // A new error in the clearing cycle wins over the clear.
        ovf_d = (ovf_q && !clr_err) || (wen && full_q);
        udf_d = (udf_q && !clr_err) || (ren && empty_q);
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; not reset, but writes in the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[waddr] <= wdata;
        end
    end

    if (FWFT == 0) begin : g_std
        logic [DSIZE-1:0] rdata_q;
        logic             rvalid_q;

        // Registered read port: data and a one-cycle valid pulse follow each accepted pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem[raddr];
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end else begin : g_fwft
        // Head entry is presented directly; driven to zero while empty so stale data never shows.
        assign rdata  = empty_q ? '0 : mem[raddr];
        assign rvalid = !empty_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a standard-mode instance tracked by a reference model
// and scoreboard queue, plus an FWFT instance checked in directed steps.
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       wen;
    logic [7:0] wdata;
    logic       ren;
    logic       clr_err;

    logic [7:0] rdata;
    logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] level;

    logic [7:0] fw_rdata;
    logic       fw_rvalid, fw_full, fw_empty, fw_afull, fw_aempty, fw_ovf, fw_udf;
    logic [4:0] fw_level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] sb[$];
    int         m_level;
    logic       m_ovf, m_udf, m_rvalid;
    logic [7:0] m_rdata;
    int         dv;

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren), .clr_err(clr_err),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) dut_fw (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren), .clr_err(clr_err),
        .rdata(fw_rdata), .rvalid(fw_rvalid), .full(fw_full), .empty(fw_empty),
        .almost_full(fw_afull), .almost_empty(fw_aempty), .level(fw_level),
        .overflow(fw_ovf), .underflow(fw_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the shared inputs; updates the model and checks the standard DUT.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c,
                        input logic rs);
        logic wa, ra;
        wen = w; wdata = d; ren = r; clr_err = c; rst = rs;
        wa = w && (m_level != 16);
        ra = r && (m_level != 0);
        if (rs) begin
            m_level = 0; sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
            m_rvalid = 1'b0; m_rdata = 8'h00;
        end else begin
            if (wa) sb.push_back(d);
            m_ovf    = (m_ovf && !c) || (w && m_level == 16);
            m_udf    = (m_udf && !c) || (r && m_level == 0);
            m_level  = m_level + int'(wa) - int'(ra);
            m_rvalid = ra;
        end
        @(posedge clk);
        #1;
        check("rvalid", rvalid, m_rvalid);
        if (rvalid === 1'b1 && !rs) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rvalid_no_data observed=rvalid expected=no_output");
            end else begin
                m_rdata = sb.pop_front();
            end
        end
        check("rdata", rdata, m_rdata);
        check("level", level, m_level);
        check("full", full, m_level == 16);
        check("empty", empty, m_level == 0);
        check("almost_full", almost_full, m_level >= 12);
        check("almost_empty", almost_empty, m_level <= 2);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; wdata = 8'h00; ren = 1'b0; clr_err = 1'b0;
        m_level = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;

        // 1. Reset, fill to full, then one write too many
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);

        // 2. Drain in order, then read while empty
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 3. Hold level 5 with simultaneous push/pop across two pointer wraps
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        dv = 8'h20;
        for (int i = 0; i < 5; i++) begin step(1'b1, 8'(dv), 1'b0, 1'b0, 1'b0); dv++; end
        for (int i = 0; i < 40; i++) begin step(1'b1, 8'(dv), 1'b1, 1'b0, 1'b0); dv++; end

        // 4. Push+pop while full, then push+pop while empty
        for (int i = 0; i < 11; i++) begin step(1'b1, 8'(dv), 1'b0, 1'b0, 1'b0); dv++; end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // 5. FWFT instance: head appears without a pop
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("fw_reset_rvalid", fw_rvalid, 1'b0);
        check("fw_reset_rdata", fw_rdata, 8'h00);
        check("fw_reset_empty", fw_empty, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("fw_head_rdata", fw_rdata, 8'hA5);
        check("fw_head_rvalid", fw_rvalid, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("fw_hold_rdata", fw_rdata, 8'hA5);
        check("fw_hold_level", fw_level, 5'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("fw_pop_empty", fw_empty, 1'b1);
        check("fw_pop_rvalid", fw_rvalid, 1'b0);

        // 6. Reset at level 9 with a write pending; clear racing a new overflow
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
